// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared widths, FSM encoding and slice helpers for the k-means
// mean-update block.
//   Channel layout of a mean:        R[23:16] G[15:8] B[7:0]
//   Channel layout of an accumulator: R[71:48] G[47:24] B[23:0]
// Channel index c (0=B, 1=G, 2=R) sits at c*CH_W in a mean and at c*SUM_W in an
// accumulator, so one loop over c covers both layouts.
package kmeans_pkg;

  localparam int PIX_W      = 24;
  localparam int CH_W       = 8;
  localparam int NUM_CH     = 3;
  localparam int SUM_W      = 24;
  localparam int ACC_W      = 72;
  localparam int CNT_W      = 12;
  localparam int DIVISOR_W  = CNT_W + 1;
  localparam int DIV_W      = 25;
  localparam int DIV_CYCLES = 25;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Bit offset of cluster k of engine e in the accumulator vector.
  function automatic int acc_off(input int e, input int k, input int t);
    return (e * t + k) * ACC_W;
  endfunction

  // Bit offset of cluster k of engine e in the counter vector.
  function automatic int cnt_off(input int e, input int k, input int t);
    return (e * t + k) * CNT_W;
  endfunction

  // Bit offset of cluster k in a mean vector.
  function automatic int mean_off(input int k);
    return k * PIX_W;
  endfunction

  // Clamp a quotient to one 8-bit channel.
  function automatic logic [CH_W-1:0] sat_channel(input logic [DIV_W-1:0] q);
    logic [CH_W-1:0] r;
    if (|q[DIV_W-1:CH_W]) begin
      r = 8'hFF;
    end else begin
      r = q[CH_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/kmeans_mean_update_serial_divider.sv
// serial_divider: restoring unsigned divider, one quotient bit per cycle,
// MSB first. Latency after load is exactly DVD_W cycles regardless of operands.
// A zero divisor yields an all-ones quotient; the caller screens that case.
//   clk, reset  : clock, asynchronous active-high reset
//   load        : latch dividend/divisor and start a division
//   dividend    : DVD_W-bit numerator
//   divisor     : DVS_W-bit denominator
//   quotient    : DVD_W-bit result (final once ready)
//   remainder   : DVS_W-bit remainder (final once ready)
//   ready       : no division in progress
module serial_divider #(
  parameter int DVD_W = 25,
  parameter int DVS_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             ready
);

  localparam int CNT_BITS = $clog2(DVD_W + 1);

  logic [DVD_W-1:0]    quo_r;
  logic [DVS_W-1:0]    rem_r;
  logic [DVS_W-1:0]    dvs_r;
  logic [CNT_BITS-1:0] cnt_r;
  logic [DVS_W:0]      partial_s;
  logic [DVS_W:0]      trial_s;
  logic                fits_s;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    partial_s = {rem_r, quo_r[DVD_W-1]};
    trial_s   = partial_s - {1'b0, dvs_r};
    fits_s    = (partial_s >= {1'b0, dvs_r});
  end

  // Division state: the dividend register doubles as the quotient shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_r <= '0;
      rem_r <= '0;
      dvs_r <= '0;
      cnt_r <= '0;
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= '0;
      dvs_r <= divisor;
      cnt_r <= CNT_BITS'(DVD_W);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CNT_BITS'(1);
      if (fits_s) begin
        rem_r <= trial_s[DVS_W-1:0];
        quo_r <= {quo_r[DVD_W-2:0], 1'b1};
      end else begin
        rem_r <= partial_s[DVS_W-1:0];
        quo_r <= {quo_r[DVD_W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign ready     = (cnt_r == '0);

endmodule

// File: rtl/kmeans_mean_update.sv
// kmeans_mean_update: merges the two engines' per-cluster accumulators and
// counters, divides sums by counts (floor, saturated to 8 bits) and produces
// the next mean set, enable mask and a convergence flag. Clusters are processed
// serially at a fixed 27 cycles each (LOAD, 25 x DIV, WRITE).
//   clk, reset   : clock, asynchronous active-high reset
//   accumolator  : ACC_W per cluster, engine 0 in the low half
//   counters     : CNT_W per cluster, same slicing
//   init         : load meanInit / enabledInit (IDLE only, wins over start)
//   meanInit     : seed means
//   enabledInit  : seed enable mask
//   start        : begin a pass (IDLE only)
//   meanOut      : current means, cluster k at k*PIX_W
//   enabled      : current enable mask
//   busy         : pass in progress
//   done         : one-cycle completion pulse
//   converged    : no mean changed in the last pass; held until next start
module kmeans_mean_update
  import kmeans_pkg::*;
#(
  parameter int T = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ACC_W*T*2-1:0] accumolator,
  input  logic [CNT_W*T*2-1:0] counters,
  input  logic                 init,
  input  logic [PIX_W*T-1:0]   meanInit,
  input  logic [T-1:0]         enabledInit,
  input  logic                 start,
  output logic [PIX_W*T-1:0]   meanOut,
  output logic [T-1:0]         enabled,
  output logic                 busy,
  output logic                 done,
  output logic                 converged
);

  localparam int KW = $clog2(T);

  logic [2:0]           state_r;
  logic [KW-1:0]        k_r;
  logic [4:0]           div_cnt_r;
  logic                 changed_r;
  logic                 div_zero_r;
  logic [PIX_W*T-1:0]   mean_r;
  logic [T-1:0]         enabled_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 converged_r;

  logic [DIV_W-1:0]     dividend_s [NUM_CH];
  logic [DIV_W-1:0]     quot_s     [NUM_CH];
  logic [DIVISOR_W-1:0] rem_s      [NUM_CH];
  logic [NUM_CH-1:0]    ready_s;
  logic [DIVISOR_W-1:0] divisor_s;
  logic [PIX_W-1:0]     old_mean_s;
  logic [PIX_W-1:0]     new_mean_s;
  logic                 load_s;
  logic                 unused_s;

  // Merge both engines' operands for the current cluster and form its new mean.
  always_comb begin
    divisor_s  = {1'b0, counters[cnt_off(0, int'(k_r), T) +: CNT_W]}
               + {1'b0, counters[cnt_off(1, int'(k_r), T) +: CNT_W]};
    old_mean_s = mean_r[mean_off(int'(k_r)) +: PIX_W];
    new_mean_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      dividend_s[c] = {1'b0, accumolator[acc_off(0, int'(k_r), T) + c * SUM_W +: SUM_W]}
                    + {1'b0, accumolator[acc_off(1, int'(k_r), T) + c * SUM_W +: SUM_W]};
      new_mean_s[c * CH_W +: CH_W] = sat_channel(quot_s[c]);
    end
  end

  assign load_s = (state_r == S_LOAD);

  genvar gc;
  generate
    for (gc = 0; gc < NUM_CH; gc++) begin : g_div
      serial_divider #(
        .DVD_W (DIV_W),
        .DVS_W (DIVISOR_W)
      ) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .dividend  (dividend_s[gc]),
        .divisor   (divisor_s),
        .quotient  (quot_s[gc]),
        .remainder (rem_s[gc]),
        .ready     (ready_s[gc])
      );
    end
  endgenerate

  // Remainders are discarded (floor division) and the pass is timed by the
  // local cycle counter, so the divider status is deliberately not consumed.
  assign unused_s = ^{rem_s[0], rem_s[1], rem_s[2], ready_s};

  // Pass sequencer plus the mean/enable/status registers it updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      k_r         <= '0;
      div_cnt_r   <= '0;
      changed_r   <= 1'b0;
      div_zero_r  <= 1'b0;
      mean_r      <= '0;
      enabled_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      converged_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (init) begin
            mean_r    <= meanInit;
            enabled_r <= enabledInit;
          end else if (start) begin
            state_r     <= S_LOAD;
            k_r         <= '0;
            changed_r   <= 1'b0;
            busy_r      <= 1'b1;
            converged_r <= 1'b0;
          end
        end
        S_LOAD: begin
          div_zero_r <= (divisor_s == '0);
          div_cnt_r  <= '0;
          state_r    <= S_DIV;
        end
        S_DIV: begin
          if (div_cnt_r == 5'(DIV_CYCLES - 1)) begin
            state_r <= S_WRITE;
          end else begin
            div_cnt_r <= div_cnt_r + 5'd1;
          end
        end
        S_WRITE: begin
          if (enabled_r[k_r]) begin
            if (div_zero_r) begin
              // Empty cluster: keep its mean, retire it from later passes.
              enabled_r[k_r] <= 1'b0;
            end else begin
              mean_r[mean_off(int'(k_r)) +: PIX_W] <= new_mean_s;
              if (new_mean_s != old_mean_s) begin
                changed_r <= 1'b1;
              end
            end
          end
          if (k_r == KW'(T - 1)) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
          end else begin
            k_r     <= k_r + KW'(1);
            state_r <= S_LOAD;
          end
        end
        S_DONE: begin
          done_r      <= 1'b1;
          converged_r <= ~changed_r;
          state_r     <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign meanOut   = mean_r;
  assign enabled   = enabled_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign converged = converged_r;

endmodule

// File: tb/tb_kmeans_mean_update.sv
// Directed self-checking bench for kmeans_mean_update (T=16).
module tb_kmeans_mean_update;

  localparam int T     = 16;
  localparam int PIX_W = 24;
  localparam int ACC_W = 72;
  localparam int CNT_W = 12;

  logic                 clk;
  logic                 reset;
  logic [ACC_W*T*2-1:0] accumolator;
  logic [CNT_W*T*2-1:0] counters;
  logic                 init;
  logic [PIX_W*T-1:0]   meanInit;
  logic [T-1:0]         enabledInit;
  logic                 start;
  logic [PIX_W*T-1:0]   meanOut;
  logic [T-1:0]         enabled;
  logic                 busy;
  logic                 done;
  logic                 converged;

  int tests;
  int fails;
  int n;
  int hits;

  kmeans_mean_update #(.T(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .accumolator (accumolator),
    .counters    (counters),
    .init        (init),
    .meanInit    (meanInit),
    .enabledInit (enabledInit),
    .start       (start),
    .meanOut     (meanOut),
    .enabled     (enabled),
    .busy        (busy),
    .done        (done),
    .converged   (converged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_acc(input int e, input int k, input logic [23:0] r,
                         input logic [23:0] g, input logic [23:0] b);
    accumolator[(e * T + k) * ACC_W +: ACC_W] = {r, g, b};
  endtask

  task automatic set_cnt(input int e, input int k, input logic [11:0] c);
    counters[(e * T + k) * CNT_W +: CNT_W] = c;
  endtask

  task automatic set_seed(input int k, input logic [23:0] m);
    meanInit[k * PIX_W +: PIX_W] = m;
  endtask

  function automatic logic [31:0] mean_of(input int k);
    return {8'd0, meanOut[k * PIX_W +: PIX_W]};
  endfunction

  task automatic do_init(input logic [15:0] en);
    @(negedge clk);
    enabledInit = en;
    init = 1'b1;
    @(posedge clk);
    #1 init = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until done; optionally pulses
  // a stray start sampled on edge stray+1. Returns 0 if done never appears.
  task automatic wait_done(input int stray, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk);
      #1;
      start = (i == stray);
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0; init = 1'b0; start = 1'b0;
    meanInit = '0; enabledInit = '0; accumolator = '0; counters = '0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_mean",      {31'd0, |meanOut}, 32'd0);
    chk("rst_mean_x",    {31'd0, ^meanOut === 1'bx}, 32'd0);
    chk("rst_enabled",   {16'd0, enabled}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_done",      {31'd0, done}, 32'd0);
    chk("rst_converged", {31'd0, converged}, 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    // Pass 1: merge, empty cluster, saturation and floor.
    set_acc(0, 3, 24'd1000, 24'd2000, 24'd0);  set_cnt(0, 3, 12'd10);
    set_acc(1, 3, 24'd500,  24'd1000, 24'd30); set_cnt(1, 3, 12'd5);
    set_acc(0, 7, 24'hFFFFFF, 24'd0, 24'd0);   set_cnt(0, 7, 12'd1);
    set_acc(0, 8, 24'd0, 24'd7, 24'd0);        set_cnt(1, 8, 12'd2);
    set_acc(0, 9, 24'hFFFFFF, 24'd0, 24'd0);   set_cnt(0, 9, 12'd1);
    set_acc(1, 9, 24'hFFFFFF, 24'd0, 24'd0);   set_cnt(1, 9, 12'd1);
    set_seed(5, 24'h112233);
    do_init(16'hFFFF);
    chk("init_enabled", {16'd0, enabled}, 32'h0000FFFF);
    chk("init_mean5",   mean_of(5), 32'h00112233);
    do_start();
    chk("p1_busy", {31'd0, busy}, 32'd1);
    wait_done(0, n);
    chk("p1_latency",   n, 32'd433);
    chk("p1_mean3",     mean_of(3), 32'h0064C802);
    chk("p1_mean5",     mean_of(5), 32'h00112233);
    chk("p1_mean7_sat", mean_of(7), 32'h00FF0000);
    chk("p1_mean8_flr", mean_of(8), 32'h00000300);
    chk("p1_mean9_sat", mean_of(9), 32'h00FF0000);
    chk("p1_mean0",     mean_of(0), 32'h00000000);
    chk("p1_enabled",   {16'd0, enabled}, 32'h00000388);
    chk("p1_converged", {31'd0, converged}, 32'd0);
    chk("p1_busy_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("p1_done_pulse", {31'd0, done}, 32'd0);

    // Pass 2: seeds equal the computed means, so nothing changes.
    set_seed(3, 24'h64C802); set_seed(7, 24'hFF0000);
    set_seed(8, 24'h000300); set_seed(9, 24'hFF0000);
    do_init(16'hFFFF);
    do_start();
    wait_done(0, n);
    chk("p2_latency",   n, 32'd433);
    chk("p2_converged", {31'd0, converged}, 32'd1);
    chk("p2_enabled",   {16'd0, enabled}, 32'h00000388);
    chk("p2_mean3",     mean_of(3), 32'h0064C802);
    @(posedge clk);
    #1;
    chk("p2_conv_held", {31'd0, converged}, 32'd1);
    chk("p2_done_low",  {31'd0, done}, 32'd0);

    // Pass 3: one count altered, plus a stray start mid-pass.
    set_cnt(1, 3, 12'd10);
    do_start();
    wait_done(100, n);
    chk("p3_latency",   n, 32'd433);
    chk("p3_mean3",     mean_of(3), 32'h004B9601);
    chk("p3_converged", {31'd0, converged}, 32'd0);
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1 || done === 1'b1) hits++;
    end
    chk("p3_stray_ignored", hits, 32'd0);

    // init and start together: seeds load, no pass runs.
    @(negedge clk);
    set_seed(0, 24'hABCDEF);
    enabledInit = 16'h00F0;
    init = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    start = 1'b0;
    chk("is_busy",    {31'd0, busy}, 32'd0);
    chk("is_mean0",   mean_of(0), 32'h00ABCDEF);
    chk("is_enabled", {16'd0, enabled}, 32'h000000F0);
    hits = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1 || done === 1'b1) hits++;
    end
    chk("is_no_pass", hits, 32'd0);

    // Reset mid-pass, then a fresh pass.
    meanInit = '0;
    do_init(16'hFFFF);
    do_start();
    repeat (199) @(posedge clk);
    @(negedge clk);
    chk("mr_mean_before", {31'd0, |meanOut}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_mean",    {31'd0, |meanOut}, 32'd0);
    chk("mr_enabled", {16'd0, enabled}, 32'd0);
    chk("mr_busy",    {31'd0, busy}, 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_idle_busy", {31'd0, busy}, 32'd0);
    do_init(16'hFFFF);
    do_start();
    wait_done(0, n);
    chk("mr_latency",   n, 32'd433);
    chk("mr_mean3",     mean_of(3), 32'h004B9601);
    chk("mr_mean7",     mean_of(7), 32'h00FF0000);
    chk("mr_mean8",     mean_of(8), 32'h00000300);
    chk("mr_mean5",     mean_of(5), 32'h00000000);
    chk("mr_enabled",   {16'd0, enabled}, 32'h00000388);
    chk("mr_converged", {31'd0, converged}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
